// File: rtl/edge_det_pkg.sv
// Shared types and default parameters for the multi-channel edge detector.
// Mode encoding and the qualify helper are common to every channel.
package edge_det_pkg;

    typedef enum logic [1:0] {
        MODE_OFF  = 2'b00,
        MODE_RISE = 2'b01,
        MODE_FALL = 2'b10,
        MODE_BOTH = 2'b11
    } mode_e;

    localparam int N_CH_DEF        = 4;
    localparam int SYNC_STAGES_DEF = 2;
    localparam int FILTER_CNT_DEF  = 3;
    localparam int CNT_W_DEF       = 4;

    // An accepted edge qualifies when the channel mode selects its direction.
    function automatic logic edge_qualifies(input mode_e m, input logic rise, input logic fall);
        logic want_rise;
        logic want_fall;
        want_rise = (m == MODE_RISE) || (m == MODE_BOTH);
        want_fall = (m == MODE_FALL) || (m == MODE_BOTH);
        return (rise & want_rise) | (fall & want_fall);
    endfunction

endpackage

// File: rtl/edge_det_chan.sv
// One edge-detector channel: synchroniser, glitch filter, registered edge pulses,
// sticky pending flag and a saturating count of qualifying edges.
module edge_det_chan
    import edge_det_pkg::*;
#(
    parameter int SYNC_STAGES = SYNC_STAGES_DEF,
    parameter int FILTER_CNT  = FILTER_CNT_DEF,
    parameter int CNT_W       = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             d,
    input  mode_e            mode,
    input  logic             clr,
    output logic             level,
    output logic             r_edge,
    output logic             f_edge,
    output logic             pend,
    output logic [CNT_W-1:0] cnt
);

    localparam int FW = (FILTER_CNT > 1) ? $clog2(FILTER_CNT) : 1;
    localparam logic [FW-1:0]    FILT_LAST = FW'(FILTER_CNT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

    logic [SYNC_STAGES-1:0] sync_reg;
    logic                   s;
    logic [FW-1:0]          filt_cnt_reg;
    logic [FW-1:0]          filt_cnt_next;
    logic                   level_reg;
    logic                   level_next;
    logic                   toggle;
    logic                   r_edge_reg;
    logic                   r_edge_next;
    logic                   f_edge_reg;
    logic                   f_edge_next;
    logic                   qual;
    logic                   pend_reg;
    logic                   pend_next;
    logic [CNT_W-1:0]       cnt_reg;
    logic [CNT_W-1:0]       cnt_next;

    assign s = sync_reg[SYNC_STAGES-1];

    // Filter: a new level is accepted only after FILTER_CNT consecutive mismatches.
    always_comb begin
        filt_cnt_next = '0;
        level_next    = level_reg;
        toggle        = 1'b0;
        if (s != level_reg) begin
            if (filt_cnt_reg == FILT_LAST) begin
                toggle     = 1'b1;
                level_next = ~level_reg;
            end else begin
                filt_cnt_next = filt_cnt_reg + 1'b1;
            end
        end
    end

    always_comb begin
        r_edge_next = toggle & ~level_reg;
        f_edge_next = toggle &  level_reg;
        qual        = edge_qualifies(mode, r_edge_next, f_edge_next);
    end

    // A qualifying edge beats a same-cycle clear, leaving one counted event.
    always_comb begin
        pend_next = qual | (pend_reg & ~clr);
        cnt_next  = cnt_reg;
        if (clr) begin
            cnt_next = qual ? CNT_W'(1) : '0;
        end else if (qual && (cnt_reg != CNT_MAX)) begin
            cnt_next = cnt_reg + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_reg     <= '0;
            filt_cnt_reg <= '0;
            level_reg    <= 1'b0;
            r_edge_reg   <= 1'b0;
            f_edge_reg   <= 1'b0;
            pend_reg     <= 1'b0;
            cnt_reg      <= '0;
        end else begin
            sync_reg     <= {sync_reg[SYNC_STAGES-2:0], d};
            filt_cnt_reg <= filt_cnt_next;
            level_reg    <= level_next;
            r_edge_reg   <= r_edge_next;
            f_edge_reg   <= f_edge_next;
            pend_reg     <= pend_next;
            cnt_reg      <= cnt_next;
        end
    end

    assign level  = level_reg;
    assign r_edge = r_edge_reg;
    assign f_edge = f_edge_reg;
    assign pend   = pend_reg;
    assign cnt    = cnt_reg;

endmodule

// File: rtl/multi_edge_detector.sv
// N-channel edge detector: independent channels with one OR-ed interrupt built
// from the registered pending flags.
module multi_edge_detector
    import edge_det_pkg::*;
#(
    parameter int N_CH        = N_CH_DEF,
    parameter int SYNC_STAGES = SYNC_STAGES_DEF,
    parameter int FILTER_CNT  = FILTER_CNT_DEF,
    parameter int CNT_W       = CNT_W_DEF
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [N_CH-1:0]         d,
    input  logic [2*N_CH-1:0]       mode,
    input  logic [N_CH-1:0]         clr,
    output logic [N_CH-1:0]         level,
    output logic [N_CH-1:0]         r_edge,
    output logic [N_CH-1:0]         f_edge,
    output logic [N_CH-1:0]         pend,
    output logic [N_CH*CNT_W-1:0]   cnt,
    output logic                    irq
);

    generate
        for (genvar gi = 0; gi < N_CH; gi++) begin : g_chan
            edge_det_chan #(
                .SYNC_STAGES (SYNC_STAGES),
                .FILTER_CNT  (FILTER_CNT),
                .CNT_W       (CNT_W)
            ) u_chan (
                .clk    (clk),
                .rst_n  (rst_n),
                .d      (d[gi]),
                .mode   (mode_e'(mode[2*gi +: 2])),
                .clr    (clr[gi]),
                .level  (level[gi]),
                .r_edge (r_edge[gi]),
                .f_edge (f_edge[gi]),
                .pend   (pend[gi]),
                .cnt    (cnt[gi*CNT_W +: CNT_W])
            );
        end
    endgenerate

    assign irq = |pend;

endmodule

// File: tb/tb_multi_edge_detector.sv
// Directed bench for multi_edge_detector with default parameters (4 ch, 2 sync, filter 3, 4-bit cnt).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_multi_edge_detector;

    logic        clk;
    logic        rst_n;
    logic [3:0]  d;
    logic [7:0]  mode;
    logic [3:0]  clr;
    logic [3:0]  level;
    logic [3:0]  r_edge;
    logic [3:0]  f_edge;
    logic [3:0]  pend;
    logic [15:0] cnt;
    logic        irq;

    int n_checks = 0;
    int n_pass   = 0;

    multi_edge_detector #(
        .N_CH(4), .SYNC_STAGES(2), .FILTER_CNT(3), .CNT_W(4)
    ) dut (
        .clk(clk), .rst_n(rst_n), .d(d), .mode(mode), .clr(clr),
        .level(level), .r_edge(r_edge), .f_edge(f_edge),
        .pend(pend), .cnt(cnt), .irq(irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Runs n cycles and counts edge pulses seen on one channel.
    task automatic run_count(input int n, input int ch, output int rc, output int fc);
        rc = 0;
        fc = 0;
        repeat (n) begin
            @(negedge clk);
            rc += int'(r_edge[ch]);
            fc += int'(f_edge[ch]);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        d     = '0;
        clr   = '0;
        mode  = 8'hFF;
        tick(2);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        d     = 4'hF;
        clr   = '0;
        mode  = 8'hFF;
        #3 rst_n = 1'b0;
        tick(6);
        n_checks++;
        if ({level, r_edge, f_edge, pend, cnt, irq} !== 33'd0)
            $display("FAIL reset_hold got lvl=%h r=%h f=%h pend=%h cnt=%h irq=%b exp all 0",
                     level, r_edge, f_edge, pend, cnt, irq);
        else n_pass++;
        d     = '0;
        rst_n = 1'b1;
        tick(8);
        n_checks++;
        if ({level, r_edge, f_edge, pend, cnt, irq} !== 33'd0)
            $display("FAIL reset_release got lvl=%h pend=%h cnt=%h irq=%b exp all 0",
                     level, pend, cnt, irq);
        else n_pass++;
        $display("test_reset done");
    endtask

    task automatic test_rise_latency();
        do_reset();
        tick(1);
        d[0] = 1'b1;
        tick(4);
        n_checks++;
        if (r_edge !== 4'h0 || level !== 4'h0)
            $display("FAIL rise_early got r=%h lvl=%h exp r=0 lvl=0", r_edge, level);
        else n_pass++;
        tick(1);
        n_checks++;
        if (r_edge !== 4'h1 || f_edge !== 4'h0 || level !== 4'h1)
            $display("FAIL rise_edge got r=%h f=%h lvl=%h exp r=1 f=0 lvl=1", r_edge, f_edge, level);
        else n_pass++;
        n_checks++;
        if (pend !== 4'h1 || cnt !== 16'h0001 || irq !== 1'b1)
            $display("FAIL rise_pend got pend=%h cnt=%h irq=%b exp pend=1 cnt=0001 irq=1",
                     pend, cnt, irq);
        else n_pass++;
        tick(1);
        n_checks++;
        if (r_edge !== 4'h0 || level !== 4'h1)
            $display("FAIL rise_oneshot got r=%h lvl=%h exp r=0 lvl=1", r_edge, level);
        else n_pass++;
        $display("test_rise_latency done");
    endtask

    task automatic test_glitch();
        int rc, fc;
        logic seen;
        do_reset();
        tick(1);
        d[1] = 1'b1;
        tick(2);
        d[1] = 1'b0;
        seen = 1'b0;
        repeat (12) begin
            @(negedge clk);
            seen |= level[1] | r_edge[1] | f_edge[1] | pend[1];
        end
        n_checks++;
        if (seen !== 1'b0 || cnt[7:4] !== 4'd0)
            $display("FAIL glitch_reject got activity=%b cnt1=%0d exp 0 and 0", seen, cnt[7:4]);
        else n_pass++;
        d[1] = 1'b1;
        tick(3);
        d[1] = 1'b0;
        run_count(15, 1, rc, fc);
        n_checks++;
        if (rc !== 1)
            $display("FAIL glitch_hold3_rise got %0d rises exp 1", rc);
        else n_pass++;
        n_checks++;
        if (fc !== 1 || level[1] !== 1'b0)
            $display("FAIL glitch_hold3_fall got %0d falls lvl=%b exp 1 falls lvl=0", fc, level[1]);
        else n_pass++;
        n_checks++;
        if (pend !== 4'h2 || cnt !== 16'h0020)
            $display("FAIL glitch_pend got pend=%h cnt=%h exp pend=2 cnt=0020", pend, cnt);
        else n_pass++;
        $display("test_glitch done");
    endtask

    task automatic test_mode();
        int rc, fc, rc2, fc2;
        do_reset();
        mode = 8'hDF;  // ch2 RISE, others BOTH
        tick(1);
        d[2] = 1'b1;
        run_count(8, 2, rc, fc);
        d[2] = 1'b0;
        run_count(8, 2, rc2, fc2);
        n_checks++;
        if (rc + rc2 !== 1 || fc + fc2 !== 1)
            $display("FAIL mode_rise_pulses got r=%0d f=%0d exp r=1 f=1", rc + rc2, fc + fc2);
        else n_pass++;
        n_checks++;
        if (cnt[11:8] !== 4'd1 || pend !== 4'h4)
            $display("FAIL mode_rise_count got cnt2=%0d pend=%h exp cnt2=1 pend=4", cnt[11:8], pend);
        else n_pass++;
        mode = 8'hCF;  // ch2 OFF
        d[2] = 1'b1;
        run_count(8, 2, rc, fc);
        d[2] = 1'b0;
        run_count(8, 2, rc2, fc2);
        n_checks++;
        if (rc + rc2 !== 1 || fc + fc2 !== 1)
            $display("FAIL mode_off_pulses got r=%0d f=%0d exp r=1 f=1", rc + rc2, fc + fc2);
        else n_pass++;
        n_checks++;
        if (cnt[11:8] !== 4'd1)
            $display("FAIL mode_off_count got cnt2=%0d exp 1", cnt[11:8]);
        else n_pass++;
        $display("test_mode done");
    endtask

    task automatic test_saturation();
        do_reset();
        tick(1);
        for (int k = 0; k < 10; k++) begin
            d[3] = 1'b1;
            tick(8);
            d[3] = 1'b0;
            tick(8);
        end
        n_checks++;
        if (cnt[15:12] !== 4'd15 || pend !== 4'h8)
            $display("FAIL sat_count got cnt3=%0d pend=%h exp cnt3=15 pend=8", cnt[15:12], pend);
        else n_pass++;
        clr[3] = 1'b1;
        tick(1);
        clr[3] = 1'b0;
        n_checks++;
        if (cnt[15:12] !== 4'd0 || pend !== 4'h0 || irq !== 1'b0)
            $display("FAIL sat_clr got cnt3=%0d pend=%h irq=%b exp 0 0 0", cnt[15:12], pend, irq);
        else n_pass++;
        d[3] = 1'b1;
        tick(4);
        clr[3] = 1'b1;
        tick(1);
        clr[3] = 1'b0;
        n_checks++;
        if (r_edge !== 4'h8)
            $display("FAIL sat_clr_edge got r=%h exp 8", r_edge);
        else n_pass++;
        n_checks++;
        if (cnt[15:12] !== 4'd1 || pend !== 4'h8)
            $display("FAIL sat_clr_qual got cnt3=%0d pend=%h exp cnt3=1 pend=8", cnt[15:12], pend);
        else n_pass++;
        $display("test_saturation done");
    endtask

    task automatic test_simultaneous();
        do_reset();
        tick(1);
        d = 4'hF;
        tick(5);
        n_checks++;
        if (r_edge !== 4'hF || level !== 4'hF)
            $display("FAIL simul_edges got r=%h lvl=%h exp F F", r_edge, level);
        else n_pass++;
        n_checks++;
        if (pend !== 4'hF || cnt !== 16'h1111)
            $display("FAIL simul_pend got pend=%h cnt=%h exp F 1111", pend, cnt);
        else n_pass++;
        clr = 4'h5;
        tick(1);
        clr = 4'h0;
        n_checks++;
        if (pend !== 4'hA || irq !== 1'b1)
            $display("FAIL simul_clr got pend=%h irq=%b exp A 1", pend, irq);
        else n_pass++;
        n_checks++;
        if (cnt !== 16'h1010)
            $display("FAIL simul_clr_cnt got %h exp 1010", cnt);
        else n_pass++;
        $display("test_simultaneous done");
    endtask

    task automatic test_async_reset();
        do_reset();
        tick(1);
        d = 4'b0010;
        tick(8);
        n_checks++;
        if (level !== 4'h2 || pend !== 4'h2)
            $display("FAIL arst_setup got lvl=%h pend=%h exp 2 2", level, pend);
        else n_pass++;
        d = 4'b0011;
        tick(4);
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({level, r_edge, f_edge, pend, cnt, irq} !== 33'd0)
            $display("FAIL arst_immediate got lvl=%h pend=%h cnt=%h irq=%b exp all 0",
                     level, pend, cnt, irq);
        else n_pass++;
        tick(2);
        rst_n = 1'b1;
        tick(4);
        n_checks++;
        if (r_edge !== 4'h0)
            $display("FAIL arst_early got r=%h exp 0", r_edge);
        else n_pass++;
        tick(1);
        n_checks++;
        if (r_edge !== 4'h3 || level !== 4'h3 || pend !== 4'h3)
            $display("FAIL arst_release got r=%h lvl=%h pend=%h exp 3 3 3", r_edge, level, pend);
        else n_pass++;
        $display("test_async_reset done");
    endtask

    initial begin
        test_reset();
        test_rise_latency();
        test_glitch();
        test_mode();
        test_saturation();
        test_simultaneous();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
